// File: rtl/mealy_11011_pkg.sv
// Shared definitions for the 11011 non-overlapping sequence detector.
package mealy_11011_pkg;

  localparam int STATE_W = 3;
  localparam logic [4:0] PATTERN = 5'b11011;

  typedef enum logic [STATE_W-1:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

endpackage

// File: rtl/mealy_11011_nol_1_always_case.sv
// Mealy detector for 1-1-0-1-1 with non-overlapping restart; out is combinational.
//
// state | meaning
// S0    | idle / no progress
// S1    | seen "1"
// S2    | seen "11" (extra 1s stay here)
// S3    | seen "110"
// S4    | seen "1101", a 1 now completes the match
module mealy_11011_nol_1_always_case
  import mealy_11011_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  state_t state;
  state_t next;

  always_ff @(posedge clk) begin
    if (rst) state <= S0;
    else     state <= next;
  end

  always_comb begin
    next = S0;
    out  = 1'b0;
    case (state)
      S0: next = in ? S1 : S0;
      S1: next = in ? S2 : S0;
      S2: next = in ? S2 : S3;
      S3: next = in ? S4 : S0;
      S4: begin
        // Detection returns to idle so the trailing "11" is not reused
        next = S0;
        out  = in;
      end
      default: begin
        next = S0;
        out  = 1'b0;
      end
    endcase
    if (rst) out = 1'b0;
  end

endmodule

// File: tb/tb_mealy_11011_nol_1_always_case.sv
// Directed and reference-model checks for the 11011 non-overlapping detector.
module tb_mealy_11011_nol_1_always_case;
  import mealy_11011_pkg::*;

  logic clk;
  logic rst;
  logic in;
  logic out;

  int n_checks = 0;
  int n_pass   = 0;

  mealy_11011_nol_1_always_case dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  // Apply one bit (with rst level), check out mid-cycle, then advance past the edge.
  task automatic step(input string tag, input logic r, input logic b, input logic exp);
    rst = r;
    in  = b;
    @(negedge clk);
    chk(tag, out, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    step(tag, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
  endtask

  // bits/exp are applied MSB first over n cycles
  task automatic run_seq(input string tag, input logic [15:0] bits,
                         input logic [15:0] exp, input int n);
    do_reset({tag, "_rst"});
    for (int i = n - 1; i >= 0; i--)
      step($sformatf("%s_b%0d", tag, n - i), 1'b0, bits[i], exp[i]);
  endtask

  initial begin
    rst = 1'b1;
    in  = 1'b0;
    @(posedge clk);
    #1;
    do_reset("init_rst");

    run_seq("basic",     16'b11011,      16'b00001,      5);
    run_seq("nonovl",    16'b11011011,   16'b00001000,   8);
    run_seq("run_of_1s", 16'b1111011,    16'b0000001,    7);
    run_seq("s4_zero",   16'b1101011011, 16'b0000000001, 10);
    run_seq("b2b",       16'b1101111011, 16'b0000100001, 10);

    // Reset mid-sequence with in=1 from S4 must force out low and clear progress
    do_reset("mid_rst_pre");
    step("mid_b1", 1'b0, 1'b1, 1'b0);
    step("mid_b2", 1'b0, 1'b1, 1'b0);
    step("mid_b3", 1'b0, 1'b0, 1'b0);
    step("mid_b4", 1'b0, 1'b1, 1'b0);
    step("mid_rst", 1'b1, 1'b1, 1'b0);
    step("mid_after", 1'b0, 1'b1, 1'b0);

    // Random stream against a window-based non-overlapping matcher
    begin
      logic [4:0] win;
      int cnt;
      logic b;
      logic e;
      do_reset("rand_rst");
      win = 5'b0;
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
        b   = ($urandom_range(0, 3) != 0);
        win = {win[3:0], b};
        cnt++;
        e = (cnt >= 5) && (win == PATTERN);
        if (e) cnt = 0;
        step($sformatf("rand_%0d", i), 1'b0, b, e);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
